user_sprite_renderer: RTL and testbench
=======================================

// Module: user_sprite_renderer
// PURPOSE
//  Downstream stage of the player-sprite position controller. Converts the live
//  sprite_x/sprite_y position into per-pixel colour for the VGA scan-out path.
//  - Latches the position once per frame (tear-free).
//  - Tests each scan pixel against the 32x32 sprite box.
//  - Fetches the texel from an external synchronous sprite ROM.
//  - Applies colour-key transparency.
//  - Emits a pipelined pixel hit/colour for the pixel mixer.
// PARAMETERS
//  SPRITE_W   32       sprite width in pixels (power of 2)
//  SPRITE_H   32       sprite height in pixels (power of 2)
//  COLOR_W    12       texel/pixel colour width (RGB444)
//  KEY_COLOR  12'hF0F  transparent texel value
//  RESET_X    280      latched x after reset
//  RESET_Y    400      latched y after reset
// PORTS
//  clk25       in   1        25 MHz pixel clock
//  rst_n       in   1        asynchronous reset, active-low
//  sprite_x    in   10       live sprite left edge from position controller
//  sprite_y    in   10       live sprite top edge from position controller
//  frame_start in   1        1-cycle pulse, first cycle of vertical blanking
//  pixel_x     in   10       current scan column
//  pixel_y     in   10       current scan row
//  video_on    in   1        1 = pixel_x/pixel_y inside visible area
//  rom_addr    out  10       sprite ROM address {row[4:0],col[4:0]}
//  rom_data    in   COLOR_W  ROM texel, valid 1 cycle after rom_addr
//  pix_valid   out  1        video_on delayed to output timing
//  pix_hit     out  1        opaque sprite texel at this pixel
//  pix_rgb     out  COLOR_W  texel when pix_hit, else 0
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - lat_x = RESET_X, lat_y = RESET_Y.
//   - rom_addr, pix_valid, pix_hit, pix_rgb and all pipeline flags = 0.
//  Position latch:
//   - On a clk25 edge with frame_start = 1: lat_x <= sprite_x, lat_y <= sprite_y.
//   - Otherwise latched values hold. Mid-frame changes of sprite_x/y never affect
//     the frame being drawn.
//   - Stage-0 compare in the frame_start cycle uses the old latch values.
//  Stage 0 (comb -> edge E1):
//   - dx = {1'b0,pixel_x} - {1'b0,lat_x}, dy likewise; 11-bit arithmetic.
//   - in_box = video_on & (pixel_x >= lat_x) & (pixel_x < lat_x+SPRITE_W)
//     & (pixel_y >= lat_y) & (pixel_y < lat_y+SPRITE_H).
//   - Sums are 11-bit, so no wrap at lat_x > 608.
//   - At E1: rom_addr <= in_box ? {dy[4:0],dx[4:0]} : 0; s1_hit <= in_box;
//     s1_vld <= video_on.
//  Stage 1 (E1 -> E2):
//   - ROM registers its data at E2.
//   - At E2: s2_hit <= s1_hit; s2_vld <= s1_vld.
//  Stage 2 (E2 -> E3):
//   - pix_hit <= s2_hit & (rom_data != KEY_COLOR).
//   - pix_rgb <= (same condition) ? rom_data : 0.
//   - pix_valid <= s2_vld.
//  Latency: exactly 3 clk25 cycles from pixel_x/pixel_y/video_on to outputs; no
//   stalls, one pixel per cycle.
//  Boundaries:
//   - Box partly off-screen: clipped by video_on.
//   - lat_x = 0: column 0 hits.
//   - Pixel at lat_x+SPRITE_W-1 hits; lat_x+SPRITE_W misses.
//   - video_on = 0: pix_hit = 0 regardless of position.
//   - Reset mid-frame: pipeline flushed, outputs 0 from reset until 3 cycles after
//     release. Latch returns to RESET_X/RESET_Y until the next frame_start.
// STRUCTURE
//  Package sprite_pkg:
//   - SPRITE_W, SPRITE_H, SCREEN_W = 640, SCREEN_H = 480, COLOR_W, KEY_COLOR.
//   - Shared with the position controller and the pixel mixer.
//  Sub-module sprite_box_test:
//   - Combinational in_box plus dx/dy offset; reused for enemy/bullet sprites.
//  Top contains the position latch and the 3-stage pipeline only.
// TESTING
//  1. Reset:
//     - Stimulus: rst_n = 0, then release.
//     - Response: outputs 0; latch = 280/400.
//     - Stimulus: pixel (280,400), video_on = 1, model ROM addr 0 = 12'h0F0.
//     - Response: 3 cycles later pix_hit = 1, pix_rgb = 12'h0F0.
//  2. Edges:
//     - Stimulus: scan row 405 across x = 279..312.
//     - Response: pix_hit only for x = 280..311; rom_addr = {5'd5,x-280}.
//  3. Key colour:
//     - Stimulus: ROM returns 12'hF0F inside the box.
//     - Response: pix_hit = 0, pix_rgb = 0, pix_valid = 1.
//  4. Tear-free:
//     - Stimulus: change sprite_x 280 -> 300 mid-frame.
//     - Response: hits stay at 280..311 until frame_start; 300..331 after it.
//  5. Clip:
//     - Stimulus: latch x = 620.
//     - Response: hits for x = 620..639 only; no wrap hit at x = 0..11.
//  6. Mid-scan reset:
//     - Stimulus: assert rst_n inside the box.
//     - Response: outputs 0 immediately (async); first valid output 3 cycles
//       after release.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sprite geometry and colour constants used by the position controller,
// the renderers and the pixel mixer.
package sprite_pkg;

  localparam int SPRITE_W = 32;
  localparam int SPRITE_H = 32;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COLOR_W  = 12;
  localparam int POS_W    = 10;

  localparam logic [COLOR_W-1:0] KEY_COLOR = 12'hF0F;

  typedef logic [POS_W-1:0] pos_t;

endpackage

// File: rtl/sprite_box_test.sv
// Combinational hit test of a scan pixel against a sprite box, plus the pixel
// offset inside the box. Shared by every sprite renderer.
module sprite_box_test
  import sprite_pkg::*;
#(
  parameter int BOX_W = SPRITE_W,
  parameter int BOX_H = SPRITE_H
) (
  input  logic [POS_W-1:0] pixel_x,
  input  logic [POS_W-1:0] pixel_y,
  input  logic [POS_W-1:0] box_x,
  input  logic [POS_W-1:0] box_y,
  input  logic             video_on,
  output logic             in_box,
  output logic [POS_W:0]   dx,
  output logic [POS_W:0]   dy
);

  logic [POS_W:0] x_end;
  logic [POS_W:0] y_end;
  logic           in_x;
  logic           in_y;

  // One extra bit keeps box ends past the right/bottom screen edge from wrapping.
  assign dx    = {1'b0, pixel_x} - {1'b0, box_x};
  assign dy    = {1'b0, pixel_y} - {1'b0, box_y};
  assign x_end = {1'b0, box_x} + (POS_W+1)'(BOX_W);
  assign y_end = {1'b0, box_y} + (POS_W+1)'(BOX_H);

  assign in_x   = (pixel_x >= box_x) && ({1'b0, pixel_x} < x_end);
  assign in_y   = (pixel_y >= box_y) && ({1'b0, pixel_y} < y_end);
  assign in_box = video_on && in_x && in_y;

endmodule

// File: rtl/user_sprite_renderer.sv
// Player sprite renderer: per-frame position latch, box test, external sprite
// ROM fetch and colour-key transparency in a fixed 3-cycle pipeline.
module user_sprite_renderer #(
  parameter int                 SPRITE_W  = sprite_pkg::SPRITE_W,
  parameter int                 SPRITE_H  = sprite_pkg::SPRITE_H,
  parameter int                 COLOR_W   = sprite_pkg::COLOR_W,
  parameter logic [COLOR_W-1:0] KEY_COLOR = sprite_pkg::KEY_COLOR,
  parameter logic [9:0]         RESET_X   = 10'd280,
  parameter logic [9:0]         RESET_Y   = 10'd400
) (
  input  logic               clk25,
  input  logic               rst_n,
  input  logic [9:0]         sprite_x,
  input  logic [9:0]         sprite_y,
  input  logic               frame_start,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic               video_on,
  output logic [9:0]         rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic               pix_valid,
  output logic               pix_hit,
  output logic [COLOR_W-1:0] pix_rgb
);
  import sprite_pkg::*;

  localparam int COL_B = $clog2(SPRITE_W);
  localparam int ROW_B = $clog2(SPRITE_H);

  logic [9:0]  lat_x;
  logic [9:0]  lat_y;
  logic        in_box_p0;
  logic [10:0] dx_p0;
  logic [10:0] dy_p0;
  logic        hit_p1;
  logic        vld_p1;
  logic        hit_p2;
  logic        vld_p2;
  logic        opaque_p2;
  logic        unused_offset_bits;

  sprite_box_test #(
    .BOX_W(SPRITE_W),
    .BOX_H(SPRITE_H)
  ) u_box (
    .pixel_x (pixel_x),
    .pixel_y (pixel_y),
    .box_x   (lat_x),
    .box_y   (lat_y),
    .video_on(video_on),
    .in_box  (in_box_p0),
    .dx      (dx_p0),
    .dy      (dy_p0)
  );

  assign unused_offset_bits = ^{dx_p0[10:COL_B], dy_p0[10:ROW_B]};
  assign opaque_p2          = hit_p2 && (rom_data != KEY_COLOR);

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      lat_x     <= RESET_X;
      lat_y     <= RESET_Y;
      rom_addr  <= '0;
      hit_p1    <= 1'b0;
      vld_p1    <= 1'b0;
      hit_p2    <= 1'b0;
      vld_p2    <= 1'b0;
      pix_valid <= 1'b0;
      pix_hit   <= 1'b0;
      pix_rgb   <= '0;
    end else begin
      // The compare in the frame_start cycle still sees the previous latch.
      if (frame_start) begin
        lat_x <= sprite_x;
        lat_y <= sprite_y;
      end
      // Stage 0 -> 1: box test result and ROM address
      rom_addr <= in_box_p0 ? 10'({dy_p0[ROW_B-1:0], dx_p0[COL_B-1:0]}) : '0;
      hit_p1   <= in_box_p0;
      vld_p1   <= video_on;
      // Stage 1 -> 2: ROM fetch in flight
      hit_p2   <= hit_p1;
      vld_p2   <= vld_p1;
      // Stage 2 -> 3: colour key and output
      pix_hit   <= opaque_p2;
      pix_rgb   <= opaque_p2 ? rom_data : '0;
      pix_valid <= vld_p2;
    end
  end

endmodule

// File: tb/tb_user_sprite_renderer.sv
// Directed bench for user_sprite_renderer with a behavioural synchronous sprite ROM.
module tb_user_sprite_renderer;

  logic        clk25 = 1'b0;
  logic        rst_n;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;
  logic        frame_start;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic [9:0]  rom_addr;
  logic [11:0] rom_data;
  logic        pix_valid;
  logic        pix_hit;
  logic [11:0] pix_rgb;
  logic        key_mode;

  int total = 0;
  int bad   = 0;

  always #20 clk25 = ~clk25;

  user_sprite_renderer dut (
    .clk25      (clk25),
    .rst_n      (rst_n),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .frame_start(frame_start),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .video_on   (video_on),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .pix_valid  (pix_valid),
    .pix_hit    (pix_hit),
    .pix_rgb    (pix_rgb)
  );

  // Address 0 holds 12'h0F0; every other address holds {2'b01, addr}, never the key.
  function automatic logic [11:0] texel(input logic [9:0] a);
    return (a == 10'd0) ? 12'h0F0 : {2'b01, a};
  endfunction

  always @(posedge clk25) rom_data <= key_mode ? 12'hF0F : texel(rom_addr);

  task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic v);
    pixel_x  = x;
    pixel_y  = y;
    video_on = v;
  endtask

  task automatic test_reset();
    logic [9:0]  vx [5];
    logic [9:0]  vy [5];
    logic [12:0] ex [5];
    vx = '{10'd280, 10'd281, 10'd279, 10'd280, 10'd0};
    vy = '{10'd400, 10'd400, 10'd400, 10'd399, 10'd0};
    ex = '{{1'b1, 12'h0F0}, {1'b1, 12'h401}, 13'h0, 13'h0, 13'h0};
    repeat (3) @(negedge clk25);
    total++;
    if ({rom_addr, pix_valid, pix_hit, pix_rgb} !== 24'h0) begin
      bad++;
      $display("FAIL reset_outputs got addr=%h v=%b h=%b rgb=%h want all 0",
               rom_addr, pix_valid, pix_hit, pix_rgb);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk25);
      if (i >= 3) begin
        total++;
        if ({pix_valid, pix_hit, pix_rgb} !== {(i - 3) < 4, ex[i-3]}) begin
          bad++;
          $display("FAIL reset_latch vec=%0d got v=%b h=%b rgb=%h want v=%b hit/rgb=%h",
                   i - 3, pix_valid, pix_hit, pix_rgb, (i - 3) < 4, ex[i-3]);
        end
      end
      if (i == 2) begin
        total++;
        if (pix_valid !== 1'b0) begin
          bad++;
          $display("FAIL reset_latency got pix_valid=%b want 0", pix_valid);
        end
      end
      if (i < 5) drive(vx[i], vy[i], i < 4);
      else drive(10'd0, 10'd0, 1'b0);
    end
  endtask

  task automatic test_edges();
    logic [9:0]  x;
    logic        eh;
    logic [9:0]  ea;
    logic [11:0] er;
    for (int i = 0; i < 37; i++) begin
      @(negedge clk25);
      if (i >= 1 && i <= 34) begin
        x  = 10'(279 + i - 1);
        ea = (x >= 280 && x <= 311) ? {5'd5, 5'(x - 10'd280)} : 10'd0;
        total++;
        if (rom_addr !== ea) begin
          bad++;
          $display("FAIL edge_addr x=%0d got %h want %h", x, rom_addr, ea);
        end
      end
      if (i >= 3) begin
        x  = 10'(279 + i - 3);
        eh = (x >= 280 && x <= 311);
        er = eh ? texel({5'd5, 5'(x - 10'd280)}) : 12'h0;
        total++;
        if ({pix_valid, pix_hit, pix_rgb} !== {1'b1, eh, er}) begin
          bad++;
          $display("FAIL edge_pix x=%0d got v=%b h=%b rgb=%h want v=1 h=%b rgb=%h",
                   x, pix_valid, pix_hit, pix_rgb, eh, er);
        end
      end
      if (i < 34) drive(10'(279 + i), 10'd405, 1'b1);
      else drive(10'd0, 10'd0, 1'b0);
    end
  endtask

  task automatic test_key();
    key_mode = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk25);
      if (i >= 3) begin
        total++;
        if ({pix_valid, pix_hit, pix_rgb} !== {1'b1, 1'b0, 12'h0}) begin
          bad++;
          $display("FAIL key_color vec=%0d got v=%b h=%b rgb=%h want v=1 h=0 rgb=000",
                   i - 3, pix_valid, pix_hit, pix_rgb);
        end
      end
      if (i < 4) drive(10'(280 + i), 10'd400, 1'b1);
      else drive(10'd0, 10'd0, 1'b0);
    end
    key_mode = 1'b0;
  endtask

  task automatic test_tear();
    logic [9:0]  x;
    logic [9:0]  base;
    logic        eh;
    logic [11:0] er;
    sprite_x = 10'd300;
    for (int pass = 0; pass < 2; pass++) begin
      base = (pass == 0) ? 10'd280 : 10'd300;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk25);
        if (i >= 3) begin
          x  = 10'(278 + i - 3);
          eh = (x >= base && x <= base + 10'd31);
          er = eh ? texel({5'd10, 5'(x - base)}) : 12'h0;
          total++;
          if ({pix_valid, pix_hit, pix_rgb} !== {1'b1, eh, er}) begin
            bad++;
            $display("FAIL tear_pass%0d x=%0d got v=%b h=%b rgb=%h want v=1 h=%b rgb=%h",
                     pass, x, pix_valid, pix_hit, pix_rgb, eh, er);
          end
        end
        if (i < 57) drive(10'(278 + i), 10'd410, 1'b1);
        else drive(10'd0, 10'd0, 1'b0);
      end
      if (pass == 0) begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk25);
          frame_start = (i == 0);
          if (i == 3) begin
            total++;
            if ({pix_valid, pix_hit, pix_rgb} !== {1'b1, 1'b1, texel({5'd10, 5'd5})}) begin
              bad++;
              $display("FAIL tear_fs_old_latch got v=%b h=%b rgb=%h want v=1 h=1 rgb=%h",
                       pix_valid, pix_hit, pix_rgb, texel({5'd10, 5'd5}));
            end
          end
          if (i == 4) begin
            total++;
            if ({pix_valid, pix_hit, pix_rgb} !== {1'b1, 1'b0, 12'h0}) begin
              bad++;
              $display("FAIL tear_fs_new_latch got v=%b h=%b rgb=%h want v=1 h=0 rgb=000",
                       pix_valid, pix_hit, pix_rgb);
            end
          end
          if (i < 2) drive(10'd285, 10'd410, 1'b1);
          else drive(10'd0, 10'd0, 1'b0);
        end
      end
    end
  endtask

  task automatic test_clip();
    logic [9:0]  x;
    logic [9:0]  y;
    logic        v;
    logic        eh;
    logic [11:0] er;
    @(negedge clk25);
    sprite_x    = 10'd620;
    frame_start = 1'b1;
    drive(10'd0, 10'd0, 1'b0);
    @(negedge clk25);
    frame_start = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk25);
      if (i >= 3) begin
        if (i - 3 < 51) begin
          x = 10'(600 + i - 3);
          y = 10'd410;
          v = (x < 640);
          eh = (x >= 620 && x <= 639);
        end else begin
          x = 10'(i - 3 - 51);
          y = 10'd411;
          v = 1'b1;
          eh = 1'b0;
        end
        er = eh ? texel({5'(y - 10'd400), 5'(x - 10'd620)}) : 12'h0;
        total++;
        if ({pix_valid, pix_hit, pix_rgb} !== {v, eh, er}) begin
          bad++;
          $display("FAIL clip x=%0d y=%0d got v=%b h=%b rgb=%h want v=%b h=%b rgb=%h",
                   x, y, pix_valid, pix_hit, pix_rgb, v, eh, er);
        end
      end
      if (i < 51) drive(10'(600 + i), 10'd410, (600 + i) < 640);
      else if (i < 67) drive(10'(i - 51), 10'd411, 1'b1);
      else drive(10'd0, 10'd0, 1'b0);
    end
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk25);
      if (i == 3) begin
        total++;
        if ({pix_valid, pix_hit, pix_rgb} !== {1'b1, 1'b1, 12'h0F0}) begin
          bad++;
          $display("FAIL midrst_prehit got v=%b h=%b rgb=%h want v=1 h=1 rgb=0f0",
                   pix_valid, pix_hit, pix_rgb);
        end
      end
      drive(10'(620 + i), 10'd400, 1'b1);
    end
    #5 rst_n = 1'b0;
    #1;
    total++;
    if ({rom_addr, pix_valid, pix_hit, pix_rgb} !== 24'h0) begin
      bad++;
      $display("FAIL midrst_async got addr=%h v=%b h=%b rgb=%h want all 0",
               rom_addr, pix_valid, pix_hit, pix_rgb);
    end
    drive(10'd284, 10'd400, 1'b1);
    repeat (2) @(negedge clk25);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk25);
      drive(10'd0, 10'd0, 1'b0);
      total++;
      if (i == 1 && {rom_addr, pix_valid} !== {10'd4, 1'b0}) begin
        bad++;
        $display("FAIL midrst_r1 got addr=%h v=%b want addr=004 v=0", rom_addr, pix_valid);
      end else if (i == 2 && {pix_valid, pix_hit, pix_rgb} !== 14'h0) begin
        bad++;
        $display("FAIL midrst_r2 got v=%b h=%b rgb=%h want all 0", pix_valid, pix_hit, pix_rgb);
      end else if (i == 3 && {pix_valid, pix_hit, pix_rgb} !== {1'b1, 1'b1, texel(10'd4)}) begin
        bad++;
        $display("FAIL midrst_r3 got v=%b h=%b rgb=%h want v=1 h=1 rgb=%h",
                 pix_valid, pix_hit, pix_rgb, texel(10'd4));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout got no finish want finish within bound");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n       = 1'b0;
    sprite_x    = 10'd280;
    sprite_y    = 10'd400;
    frame_start = 1'b0;
    key_mode    = 1'b0;
    drive(10'd0, 10'd0, 1'b0);
    test_reset();
    test_edges();
    test_key();
    test_tear();
    test_clip();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
